// File: rtl/ev19_fetch_pkg.sv
// Shared types for the EV19 instruction-fetch path: ROM geometry, the
// prefetch entry layout and the fetch master's state encoding.
package ev19_fetch_pkg;

  localparam int ROM_ADDR_W = 12;
  localparam int INSN_W     = 32;

  typedef struct packed {
    logic [ROM_ADDR_W-1:0] addr;
    logic [INSN_W-1:0]     data;
  } fetch_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Shift-style prefetch FIFO: entry 0 is always the oldest word and is a flop,
// so the head presented to the core is registered.
module fetch_fifo
  import ev19_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           wdata,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] wr_idx;
  logic             pop_en;

  // A pop shifts everything down one slot, so the write slot moves with it.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    pop_en  = pop && (count_q != '0);
    wr_idx  = pop_en ? (count_q - CNT_W'(1)) : count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (pop_en) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem_d[i] = mem_q[i+1];
        end
      end
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_idx == CNT_W'(i)) begin
            mem_d[i] = wdata;
          end
        end
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop_en);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[0];
  assign count = count_q;

endmodule

// File: rtl/rom_fetch_master.sv
// Avalon-MM read master streaming sequential instruction words from the
// fixed-latency boot ROM into the EV19 fetch stage, with redirect support.
module rom_fetch_master
  import ev19_fetch_pkg::*;
#(
  parameter int ADDR_W       = ROM_ADDR_W,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_data,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              avm_chipselect,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_write,
  output logic              avm_clken,
  input  logic [31:0]       avm_readdata
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 2;

  fetch_state_e            state_q;
  fetch_state_e            state_d;
  logic [ADDR_W-1:0]       pc_q;
  logic [ADDR_W-1:0]       pc_d;
  logic [READ_LATENCY-1:0] fl_valid_q;
  logic [READ_LATENCY-1:0] fl_valid_d;
  logic [ADDR_W-1:0]       fl_addr_q [READ_LATENCY];
  logic [ADDR_W-1:0]       fl_addr_d [READ_LATENCY];

  logic [CNT_W-1:0]        fifo_count;
  logic [SUM_W-1:0]        in_flight;
  logic                    issue;
  logic                    capture;
  logic                    pop;
  fetch_entry_t            cap_entry;
  fetch_entry_t            head;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + SUM_W'(fl_valid_q[i]);
    end
  end

  // Credit check: every issued read already owns a FIFO slot, so no overflow.
  assign issue = (state_q == RUN) && !redirect_valid &&
                 ((SUM_W'(fifo_count) + in_flight) < SUM_W'(FIFO_DEPTH));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fl_valid_d = fl_valid_q;
    fl_addr_d  = fl_addr_q;

    case (state_q)
      IDLE:    if (fetch_en)  state_d = RUN;
      RUN:     if (!fetch_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      pc_d       = redirect_addr;
      fl_valid_d = '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        fl_valid_d[i] = fl_valid_q[i-1];
        fl_addr_d[i]  = fl_addr_q[i-1];
      end
      fl_valid_d[0] = issue;
      fl_addr_d[0]  = pc_q;
      if (issue) begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      fl_valid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        fl_addr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fl_valid_q <= fl_valid_d;
      fl_addr_q  <= fl_addr_d;
    end
  end

  // A redirect in the capture cycle drops the returning stale word.
  assign capture        = fl_valid_q[READ_LATENCY-1] && !redirect_valid;
  assign cap_entry.addr = fl_addr_q[READ_LATENCY-1];
  assign cap_entry.data = avm_readdata;
  assign pop            = fetch_valid && fetch_ready;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (redirect_valid),
    .push    (capture),
    .wdata   (cap_entry),
    .pop     (pop),
    .head    (head),
    .count   (fifo_count)
  );

  assign fetch_valid    = (fifo_count != '0);
  assign fetch_data     = head.data;
  assign fetch_addr     = head.addr;

  assign avm_chipselect = issue;
  assign avm_address    = pc_q;
  assign avm_byteenable = 4'hF;
  assign avm_write      = 1'b0;
  assign avm_clken      = 1'b1;

endmodule

// File: tb/tb_rom_fetch_master.sv
// Randomized and directed bench for rom_fetch_master against a
// transaction-level model of issued-but-unconsumed words.
module tb_rom_fetch_master;

  localparam int ADDR_W = 12;
  localparam int RL     = 1;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              fetch_en = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_addr = '0;
  logic              fetch_ready = 1'b0;
  logic              fetch_valid;
  logic [31:0]       fetch_data;
  logic [ADDR_W-1:0] fetch_addr;
  logic              avm_chipselect;
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_write;
  logic              avm_clken;
  logic [31:0]       avm_readdata;
  logic [31:0]       rom_pipe [RL];

  rom_fetch_master #(
    .ADDR_W       (ADDR_W),
    .READ_LATENCY (RL),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .fetch_data     (fetch_data),
    .fetch_addr     (fetch_addr),
    .avm_chipselect (avm_chipselect),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_write      (avm_write),
    .avm_clken      (avm_clken),
    .avm_readdata   (avm_readdata)
  );

  always #5 clk = ~clk;

  // Fixed-latency ROM: word k holds A000_0000 + k.
  always @(posedge clk) begin
    rom_pipe[0] <= 32'hA000_0000 + {20'h0, avm_address};
    for (int i = 1; i < RL; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign avm_readdata = rom_pipe[RL-1];

  typedef struct {
    int                t;
    logic [ADDR_W-1:0] addr;
  } issue_t;

  issue_t            mq[$];
  logic [ADDR_W-1:0] acc_q[$];
  int                cyc = 0;
  logic [ADDR_W-1:0] m_pc = '0;
  bit                m_run = 1'b0;
  int                checks = 0;
  int                errors = 0;
  logic              s_valid;
  logic              s_cs;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance model.
  task automatic applyStimulus(input bit en, input bit rv, input logic [ADDR_W-1:0] ra, input bit rdy);
    bit exp_cs;
    bit exp_valid;
    fetch_en = en;
    redirect_valid = rv;
    redirect_addr = ra;
    fetch_ready = rdy;
    #1;
    s_valid = fetch_valid;
    s_cs = avm_chipselect;
    exp_cs = m_run && !rv && (mq.size() < DEPTH);
    checkOutput("chipselect", {31'h0, avm_chipselect}, {31'h0, exp_cs});
    if (exp_cs) checkOutput("avm_address", {20'h0, avm_address}, {20'h0, m_pc});
    exp_valid = (mq.size() > 0) && (mq[0].t + RL + 1 <= cyc);
    checkOutput("fetch_valid", {31'h0, fetch_valid}, {31'h0, exp_valid});
    if (exp_valid) begin
      checkOutput("fetch_addr", {20'h0, fetch_addr}, {20'h0, mq[0].addr});
      checkOutput("fetch_data", fetch_data, 32'hA000_0000 + {20'h0, mq[0].addr});
    end
    if (rv) begin
      mq.delete();
      m_pc = ra;
    end else begin
      if (exp_valid && rdy) begin
        acc_q.push_back(mq[0].addr);
        void'(mq.pop_front());
      end
      if (exp_cs) begin
        mq.push_back('{cyc, m_pc});
        m_pc = m_pc + 1'b1;
      end
    end
    m_run = en;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, {31'h0, fetch_valid}, 32'h0);
    checkOutput({tag, "_data"}, fetch_data, 32'h0);
    checkOutput({tag, "_addr"}, {20'h0, fetch_addr}, 32'h0);
    checkOutput({tag, "_cs"}, {31'h0, avm_chipselect}, 32'h0);
    checkOutput({tag, "_avm_addr"}, {20'h0, avm_address}, 32'h0);
  endtask

  initial begin
    int t0;
    int first;
    int base;
    int n_cs;
    int exp_cs_n;
    logic [ADDR_W-1:0] w;

    #12;
    checkResetOutputs("reset");
    checkOutput("avm_consts", {26'h0, avm_byteenable, avm_write, avm_clken}, 32'h3D);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Streaming from reset
    t0 = cyc;
    first = -1;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b1);
      if (s_valid && first < 0) first = cyc - 1 - t0;
    end
    checkOutput("stream_first_valid", first, 3);
    checkOutput("stream_count", acc_q.size(), 9);

    // Backpressure, then drain with fetch disabled
    exp_cs_n = DEPTH - mq.size();
    n_cs = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      if (s_cs) n_cs++;
    end
    checkOutput("bp_issue_count", n_cs, exp_cs_n);
    checkOutput("bp_cs_stalled", {31'h0, s_cs}, 32'h0);
    base = acc_q.size();
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("bp_drained_words", acc_q.size() - base, DEPTH);
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < acc_q.size(); i++) begin
      w = acc_q[i];
      checkOutput("bp_sequence", {20'h0, w}, i);
    end

    // Redirect with a full pipeline
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, '0, 1'b0);
    base = acc_q.size();
    t0 = cyc;
    applyStimulus(1'b1, 1'b1, 12'h100, 1'b0);
    first = -1;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b1);
      if (s_valid && first < 0) first = cyc - 1 - t0;
    end
    checkOutput("redir_first_valid", first, 3);
    checkOutput("redir_first_addr", (acc_q.size() > base) ? {20'h0, acc_q[base]} : 32'hFFFF_FFFF, 32'h100);

    // Wrap-around
    base = acc_q.size();
    applyStimulus(1'b1, 1'b1, 12'hFFE, 1'b1);
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      w = 12'hFFE + i[ADDR_W-1:0];
      checkOutput("wrap_addr", (acc_q.size() > base + i) ? {20'h0, acc_q[base+i]} : 32'hFFFF_FFFF, {20'h0, w});
    end

    // Redirect coinciding with a pop and a tail capture
    base = acc_q.size();
    applyStimulus(1'b1, 1'b1, 12'h200, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    checkOutput("simul_empty", {31'h0, s_valid}, 32'h0);
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b0, '0, 1'b1);
    checkOutput("simul_next_addr", (acc_q.size() > base) ? {20'h0, acc_q[base]} : 32'hFFFF_FFFF, 32'h200);

    // Asynchronous reset mid-stream
    #2;
    reset_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    mq.delete();
    acc_q.delete();
    m_pc = '0;
    m_run = 1'b0;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    t0 = cyc;
    first = -1;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b1);
      if (s_valid && first < 0) first = cyc - 1 - t0;
    end
    checkOutput("restart_first_valid", first, 3);
    checkOutput("restart_first_addr", (acc_q.size() > 0) ? {20'h0, acc_q[0]} : 32'hFFFF_FFFF, 32'h0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic [ADDR_W-1:0] ra;
      ra = ($urandom_range(0, 1) == 0) ? (12'hFF0 + 12'($urandom_range(0, 15))) : 12'($urandom());
      applyStimulus($urandom_range(0, 15) != 0, $urandom_range(0, 24) == 0, ra, $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
